// File: rtl/score_bcd_encoder.sv
// Sequential double-dabble converter: binary score -> two BCD digits for the score display.
// Optional macro SCORE_BLANK_OVERFLOW_EN: out-of-range scores display as blank (4'hF, 4'hF).
module score_bcd_encoder #(
  parameter int BIN_WIDTH = 7,
  parameter int MAX_SCORE = 99
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BIN_WIDTH-1:0] bin_score,
  output logic [3:0]           value0,
  output logic [3:0]           value1,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int CW = $clog2(BIN_WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [BIN_WIDTH-1:0] MAX_VAL  = BIN_WIDTH'(MAX_SCORE);
  localparam logic [CW-1:0]        CNT_INIT = CW'(BIN_WIDTH);

  logic [1:0]           state;
  logic [CW-1:0]        count;
  logic [BIN_WIDTH-1:0] operand;
  logic [7:0]           bcd;
  logic [7:0]           bcd_adj;
  logic                 ovf;

  // Add-3 correction per BCD nibble, applied before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd[gi*4 +: 4] >= 4'd5) ? (bcd[gi*4 +: 4] + 4'd3)
                                                          : bcd[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      operand  <= '0;
      bcd      <= '0;
      ovf      <= 1'b0;
      value0   <= 4'd0;
      value1   <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (bin_score > MAX_VAL) begin
              operand <= MAX_VAL;
              ovf     <= 1'b1;
            end else begin
              operand <= bin_score;
              ovf     <= 1'b0;
            end
            bcd   <= '0;
            count <= CNT_INIT;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The MSB of the corrected BCD falls off the top; it is always 0 for scores <= 99.
          {bcd, operand} <= {bcd_adj, operand} << 1;
          count          <= count - CW'(1);
          if (count == CW'(1)) begin
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH: begin
`ifdef SCORE_BLANK_OVERFLOW_EN
          if (ovf) begin
            value0 <= 4'hF;
            value1 <= 4'hF;
          end else begin
            value0 <= bcd[3:0];
            value1 <= bcd[7:4];
          end
`else
          value0 <= bcd[3:0];
          value1 <= bcd[7:4];
`endif
          overflow <= ovf;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
